// File: rtl/entrada_operandos_bcd.sv
// entrada_operandos_bcd
// Operand-entry controller for the 4-bit ALU. It takes decimal digits from
// switches and two push-buttons, accumulates each operand in decimal, and
// range-checks it. It then hands binary A, B and the opcode to the ALU over a
// valid/ready handshake.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   SW_digit[3:0]     BCD digit, sampled on an accepted KEY_digit press
//   SW_op[2:0]        opcode, sampled when operand B is confirmed
//   KEY_digit         raw button, enter digit
//   KEY_next          raw button, confirm operand
//   ready_in          ALU accepts the operand set
//   A_out, B_out      binary operands
//   OP_out            latched opcode
//   valid_out         A/B/OP hold a complete set
//   acc_out[6:0]      value being entered (0..99)
//   LED_state[1:0]    00 = S_A, 01 = S_B, 10 = S_SEND
//   LED_ERR           sticky entry error
//
// state  | meaning
// S_A    | entering operand A
// S_B    | entering operand B
// S_SEND | operand set presented, waiting for ready_in
module entrada_operandos_bcd #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_VAL         = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] SW_digit,
    input  logic [2:0] SW_op,
    input  logic       KEY_digit,
    input  logic       KEY_next,
    input  logic       ready_in,
    output logic [3:0] A_out,
    output logic [3:0] B_out,
    output logic [2:0] OP_out,
    output logic       valid_out,
    output logic [6:0] acc_out,
    output logic [1:0] LED_state,
    output logic       LED_ERR
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_SEND = 2'b10
    } state_t;

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]     MAX_ACC  = 7'(MAX_VAL);

    // ---------------- button conditioning ----------------
    // index 0 = KEY_digit, index 1 = KEY_next
    logic [1:0]    raw;
    logic [1:0]    sync1, sync2, level, pulse;
    logic [CW-1:0] cnt [2];

    assign raw = {KEY_next, KEY_digit};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] != level[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        // Count reaches DEBOUNCE_CYCLES on this edge: flip.
                        level[i] <= ~level[i];
                        cnt[i]   <= '0;
                        pulse[i] <= ~level[i];   // only on 0->1
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // ---------------- controller ----------------
    state_t     state, state_n;
    logic [6:0] acc, acc_n, acc_tmp;
    logic [1:0] dig, dig_n, dig_tmp;
    logic [3:0] a_q, a_n, b_q, b_n;
    logic [2:0] op_q, op_n;
    logic       valid_q, valid_n;
    logic       err_q, err_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_A;
            acc     <= '0;
            dig     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            dig     <= dig_n;
            a_q     <= a_n;
            b_q     <= b_n;
            op_q    <= op_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        dig_n   = dig;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        valid_n = valid_q;
        err_n   = err_q;
        acc_tmp = acc;
        dig_tmp = dig;

        if (state == S_SEND) begin
            // Presses are dropped here; only the handshake matters.
            if (valid_q && ready_in) begin
                valid_n = 1'b0;
                err_n   = 1'b0;
                state_n = S_A;
            end
        end else begin
            // Digit applies first so a simultaneous confirm sees it.
            if (pulse[0]) begin
                if (SW_digit <= 4'd9 && dig < 2'd2) begin
                    // acc <= 9 whenever dig < 2, so the result fits 0..99.
                    acc_tmp = acc * 7'd10 + {3'b000, SW_digit};
                    dig_tmp = dig + 2'd1;
                    err_n   = 1'b0;
                end else begin
                    err_n = 1'b1;
                end
            end
            acc_n = acc_tmp;
            dig_n = dig_tmp;

            if (pulse[1]) begin
                acc_n = '0;
                dig_n = '0;
                if (acc_tmp <= MAX_ACC) begin
                    if (state == S_A) begin
                        a_n     = acc_tmp[3:0];
                        state_n = S_B;
                    end else begin
                        b_n     = acc_tmp[3:0];
                        op_n    = SW_op;
                        valid_n = 1'b1;
                        state_n = S_SEND;
                    end
                end else begin
                    err_n = 1'b1;
                end
            end
        end
    end

    assign A_out     = a_q;
    assign B_out     = b_q;
    assign OP_out    = op_q;
    assign valid_out = valid_q;
    assign acc_out   = acc;
    assign LED_state = state;
    assign LED_ERR   = err_q;

endmodule
